// File: rtl/button_press_classifier.sv
// Turns debounced button edges into one-cycle short-press,
// long-press and double-click event pulses.
module button_press_classifier #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 12_500_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic p_edge,
    input  logic n_edge,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESS
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_short;
    logic             next_long;
    logic             next_double;
    logic             pe;
    logic             ne;

    // Simultaneous edges are illegal upstream and count as no edge
    assign pe = p_edge & ~n_edge;
    assign ne = n_edge & ~p_edge;

    always_comb begin
        next_state  = state;
        next_cnt    = '0;
        next_short  = 1'b0;
        next_long   = 1'b0;
        next_double = 1'b0;
        unique case (state)
            IDLE: begin
                if (pe) next_state = PRESSED;
            end
            PRESSED: begin
                if (ne) begin
                    next_state = WAIT_SECOND;
                end else if (cnt == LONG_LAST) begin
                    next_state = LONG_HELD;
                    next_long  = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (ne) next_state = IDLE;
            end
            WAIT_SECOND: begin
                if (pe) begin
                    next_state  = SECOND_PRESS;
                    next_double = 1'b1;
                end else if (cnt == DCLICK_LAST) begin
                    next_state = IDLE;
                    next_short = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            SECOND_PRESS: begin
                if (ne) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            held         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            short_press  <= next_short;
            long_press   <= next_long;
            double_click <= next_double;
            held         <= level;
            busy         <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with short timing
// parameters; edges are numbered from 1 within each scenario.
module tb_button_press_classifier;

    logic clk = 1'b0;
    logic reset;
    logic level;
    logic p_edge;
    logic n_edge;
    logic short_press;
    logic long_press;
    logic double_click;
    logic held;
    logic busy;

    int errors = 0;
    int checks = 0;
    logic lvl = 1'b0;

    always #5 clk = ~clk;

    button_press_classifier #(
        .LONG_CYCLES  (8),
        .DCLICK_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .p_edge      (p_edge),
        .n_edge      (n_edge),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .held        (held),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs edges 1..last; events/busy expectations are hand-derived edge numbers
    task automatic scen(input string nm,
                        input int p1, input int n1, input int p2, input int n2,
                        input int bth, input int rst,
                        input int es, input int el, input int ed,
                        input int b1, input int e1, input int b2, input int e2,
                        input int last);
        for (int k = 1; k <= last; k++) begin
            p_edge = (k == p1) || (k == p2) || (k == bth);
            n_edge = (k == n1) || (k == n2) || (k == bth);
            reset  = (k == rst);
            if (k == p1 || k == p2) lvl = 1'b1;
            if (k == n1 || k == n2) lvl = 1'b0;
            level = lvl;
            @(posedge clk);
            #1;
            chk($sformatf("%s.short@%0d", nm, k), short_press, k == es);
            chk($sformatf("%s.long@%0d", nm, k), long_press, k == el);
            chk($sformatf("%s.dbl@%0d", nm, k), double_click, k == ed);
            chk($sformatf("%s.held@%0d", nm, k), held, (k == rst) ? 1'b0 : lvl);
            chk($sformatf("%s.busy@%0d", nm, k), busy,
                (k >= b1 && k < e1) || (k >= b2 && k < e2));
        end
        p_edge = 1'b0;
        n_edge = 1'b0;
        reset  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        level  = 1'b0;
        p_edge = 1'b0;
        n_edge = 1'b0;

        for (int k = 0; k < 3; k++) begin
            level  = k[0];
            p_edge = ~k[0];
            @(posedge clk);
            #1;
            chk($sformatf("rst.short@%0d", k), short_press, 1'b0);
            chk($sformatf("rst.long@%0d", k), long_press, 1'b0);
            chk($sformatf("rst.dbl@%0d", k), double_click, 1'b0);
            chk($sformatf("rst.held@%0d", k), held, 1'b0);
            chk($sformatf("rst.busy@%0d", k), busy, 1'b0);
        end
        reset  = 1'b0;
        level  = 1'b0;
        p_edge = 1'b0;
        lvl    = 1'b0;
        scen("idle", -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 5);

        scen("short", 10, 13, -1, -1, -1, -1, 17, -1, -1, 10, 17, -1, -1, 20);
        scen("long", 10, 30, -1, -1, -1, -1, -1, 18, -1, 10, 30, -1, -1, 32);
        scen("bnd18", 10, 18, -1, -1, -1, -1, 22, -1, -1, 10, 22, -1, -1, 24);
        scen("bnd19", 10, 19, -1, -1, -1, -1, -1, 18, -1, 10, 19, -1, -1, 21);
        scen("dclk", 10, 12, 16, 40, -1, -1, -1, -1, 16, 10, 40, -1, -1, 42);
        scen("late2", 10, 12, 17, 40, -1, -1, 16, 25, -1, 10, 16, 17, 40, 42);
        scen("both", 10, 14, -1, -1, 12, -1, 18, -1, -1, 10, 18, -1, -1, 20);
        scen("rstmid", 10, -1, 20, 21, -1, 14, 25, -1, -1, 10, 14, 20, 25, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
